// File: rtl/regfile_pkg.sv
// Shared constants for the register file: default entry width and address width.
package regfile_pkg;
  localparam int unsigned RF_BW_DATA = 16;
  localparam int unsigned RF_BW_ADDR = 4;
endpackage

// File: rtl/regfile.sv
// Register file: one synchronous write port, two combinational read ports.
// The whole array clears asynchronously on reset.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned BW_DATA = RF_BW_DATA,
  parameter int unsigned BW_ADDR = RF_BW_ADDR
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_rf_wr_en,
  input  logic [BW_ADDR-1:0] i_rf_wr_addr,
  input  logic [BW_DATA-1:0] i_rf_wr_data,
  input  logic [BW_ADDR-1:0] i_rf_rd_addr0,
  input  logic [BW_ADDR-1:0] i_rf_rd_addr1,
  output logic [BW_DATA-1:0] o_rf_rd_data0,
  output logic [BW_DATA-1:0] o_rf_rd_data1
);

  localparam int unsigned DEPTH = 2 ** BW_ADDR;

  logic [BW_DATA-1:0] rf_arr [DEPTH];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rf_arr[i] <= '0;
      end
    end else if (i_rf_wr_en) begin
      rf_arr[i_rf_wr_addr] <= i_rf_wr_data;
    end
  end

  // No bypass: reads see the stored value, so a same-cycle write shows after the edge.
  assign o_rf_rd_data0 = rf_arr[i_rf_rd_addr0];
  assign o_rf_rd_data1 = rf_arr[i_rf_rd_addr1];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile against an array-based reference model.
module tb_regfile;

  localparam int unsigned BW_DATA = 16;
  localparam int unsigned BW_ADDR = 4;
  localparam int unsigned DEPTH   = 16;

  logic               clk;
  logic               rst_n;
  logic               wr_en;
  logic [BW_ADDR-1:0] wr_addr;
  logic [BW_DATA-1:0] wr_data;
  logic [BW_ADDR-1:0] rd_addr0;
  logic [BW_ADDR-1:0] rd_addr1;
  logic [BW_DATA-1:0] rd_data0;
  logic [BW_DATA-1:0] rd_data1;

  logic [BW_DATA-1:0] model [DEPTH];

  int checks = 0;
  int errors = 0;

  regfile #(
    .BW_DATA(BW_DATA),
    .BW_ADDR(BW_ADDR)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rst_n),
    .i_rf_wr_en   (wr_en),
    .i_rf_wr_addr (wr_addr),
    .i_rf_wr_data (wr_data),
    .i_rf_rd_addr0(rd_addr0),
    .i_rf_rd_addr1(rd_addr1),
    .o_rf_rd_data0(rd_data0),
    .o_rf_rd_data1(rd_data1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply one write cycle (possibly disabled) and update the model after the edge.
  task automatic do_cycle(input logic en, input logic [BW_ADDR-1:0] a, input logic [BW_DATA-1:0] d);
    @(negedge clk);
    wr_en = en; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1;
    if (en && rst_n) model[a] = d;
    wr_en = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hAAAA;
    rd_addr0 = 4'd5; rd_addr1 = 4'd15;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd_data0 !== 16'h0) begin
      errors++; $display("FAIL reset_rd0 got %h exp %h", rd_data0, 16'h0);
    end
    checks++;
    if (rd_data1 !== 16'h0) begin
      errors++; $display("FAIL reset_rd1 got %h exp %h", rd_data1, 16'h0);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < int'(DEPTH); i++) do_cycle(1'b1, BW_ADDR'(i), BW_DATA'(i));
    for (int i = 0; i < int'(DEPTH); i++) begin
      rd_addr0 = BW_ADDR'(i); rd_addr1 = BW_ADDR'(i);
      #1;
      checks++;
      if (rd_data0 !== BW_DATA'(i) || rd_data1 !== BW_DATA'(i)) begin
        errors++;
        $display("FAIL fill_readback addr %0d got %h/%h exp %h", i, rd_data0, rd_data1, BW_DATA'(i));
      end
    end
  endtask

  task automatic test_dual_port();
    rd_addr0 = 4'd0; rd_addr1 = 4'd15;
    #1;
    checks++;
    if (rd_data0 !== 16'd0 || rd_data1 !== 16'd15) begin
      errors++; $display("FAIL dual_port got %h/%h exp 0000/000f", rd_data0, rd_data1);
    end
  endtask

  task automatic test_write_disable();
    do_cycle(1'b0, 4'd3, 16'hFFFF);
    rd_addr0 = 4'd3; rd_addr1 = 4'd3;
    #1;
    checks++;
    if (rd_data0 !== 16'd3 || rd_data1 !== 16'd3) begin
      errors++; $display("FAIL write_disable got %h/%h exp 0003", rd_data0, rd_data1);
    end
  endtask

  task automatic test_single_write();
    do_cycle(1'b1, 4'd7, 16'hBEEF);
    rd_addr0 = 4'd7; rd_addr1 = 4'd7;
    #1;
    checks++;
    if (rd_data0 !== 16'hBEEF || rd_data1 !== 16'hBEEF) begin
      errors++; $display("FAIL write_beef got %h/%h exp beef", rd_data0, rd_data1);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      rd_addr0 = BW_ADDR'(i); rd_addr1 = BW_ADDR'(DEPTH - 1 - i);
      #1;
      checks++;
      if (rd_data0 !== model[i] || rd_data1 !== model[DEPTH-1-i]) begin
        errors++;
        $display("FAIL others_unchanged addr %0d got %h/%h exp %h/%h", i, rd_data0, rd_data1,
                 model[i], model[DEPTH-1-i]);
      end
    end
  endtask

  task automatic test_read_during_write();
    logic [BW_DATA-1:0] old_val;
    old_val = model[2];
    @(negedge clk);
    rd_addr0 = 4'd2; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h1234;
    #1;
    checks++;
    if (rd_data0 !== old_val) begin
      errors++; $display("FAIL rdw_before got %h exp %h", rd_data0, old_val);
    end
    @(posedge clk);
    #1;
    model[2] = 16'h1234;
    wr_en = 1'b0;
    checks++;
    if (rd_data0 !== 16'h1234) begin
      errors++; $display("FAIL rdw_after got %h exp 1234", rd_data0);
    end
  endtask

  task automatic test_random();
    logic               en;
    logic [BW_ADDR-1:0] a;
    logic [BW_DATA-1:0] d;
    for (int n = 0; n < 300; n++) begin
      en = 1'($urandom_range(0, 1));
      a  = BW_ADDR'($urandom_range(0, DEPTH - 1));
      d  = BW_DATA'($urandom);
      if (n % 7 == 0) d = (n % 2 == 0) ? 16'hFFFF : 16'h0000;
      @(negedge clk);
      rd_addr0 = BW_ADDR'($urandom_range(0, DEPTH - 1));
      rd_addr1 = (n % 5 == 0) ? a : BW_ADDR'($urandom_range(0, DEPTH - 1));
      wr_en = en; wr_addr = a; wr_data = d;
      #1;
      checks++;
      if (rd_data0 !== model[rd_addr0] || rd_data1 !== model[rd_addr1]) begin
        errors++;
        $display("FAIL random_read iter %0d got %h/%h exp %h/%h", n, rd_data0, rd_data1,
                 model[rd_addr0], model[rd_addr1]);
      end
      @(posedge clk);
      #1;
      if (en) model[a] = d;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h5A5A;
    rd_addr0 = 4'd7; rd_addr1 = 4'd9;
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    checks++;
    if (rd_data0 !== 16'h0 || rd_data1 !== 16'h0) begin
      errors++; $display("FAIL async_clear got %h/%h exp 0000", rd_data0, rd_data1);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rd_addr0 = BW_ADDR'(i);
      #1;
      checks++;
      if (rd_data0 !== 16'h0) begin
        errors++; $display("FAIL wr_ignored_in_reset addr %0d got %h exp 0000", i, rd_data0);
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    do_cycle(1'b1, 4'd9, 16'hC3C3);
    rd_addr1 = 4'd9;
    #1;
    checks++;
    if (rd_data1 !== model[9]) begin
      errors++; $display("FAIL write_after_reset got %h exp %h", rd_data1, model[9]);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr0 = '0; rd_addr1 = '0;
    test_reset();
    test_fill();
    test_dual_port();
    test_write_disable();
    test_single_write();
    test_read_during_write();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter BW_DATA, default 16: bit width of each register entry and of the data ports.
REQ-002 SHALL have parameter BW_ADDR, default 4: address width; depth = 2**BW_ADDR entries (16 by default).
REQ-003 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_rf_wr_en, input, 1 bit: write enable, sampled at the i_clk rising edge.
REQ-006 SHALL have port i_rf_wr_addr, input, BW_ADDR bits: write address.
REQ-007 SHALL have port i_rf_wr_data, input, BW_DATA bits: write data.
REQ-008 SHALL have port i_rf_rd_addr0, input, BW_ADDR bits: read port 0 address.
REQ-009 SHALL have port i_rf_rd_addr1, input, BW_ADDR bits: read port 1 address.
REQ-010 SHALL have port o_rf_rd_data0, output, BW_DATA bits: read port 0 data.
REQ-011 SHALL have port o_rf_rd_data1, output, BW_DATA bits: read port 1 data.

Function
REQ-012 SHALL hold storage as an array named rf_arr of 2**BW_ADDR entries, each BW_DATA bits, addressable individually for waveform dumping.
REQ-013 SHALL, on an i_clk rising edge with i_rf_wr_en=1, write i_rf_wr_data into rf_arr[i_rf_wr_addr]; write latency is 1 edge.
REQ-014 SHALL leave every entry unchanged when i_rf_wr_en=0.
REQ-015 SHALL drive both read ports combinationally: o_rf_rd_dataN = rf_arr[i_rf_rd_addrN], with zero-cycle latency.
REQ-016 SHALL let both read ports address any entries independently, including the same entry or the write entry.
REQ-017 SHALL have no write-to-read bypass: a read of the address being written returns the old value until the write edge and the new value immediately after it.
REQ-018 SHALL accept every address value 0..2**BW_ADDR-1; no out-of-range case exists and no entry is read-only or hardwired.
REQ-019 SHALL accept the full data range 0..2**BW_DATA-1 with no truncation or sign handling.
REQ-020 SHALL update exactly one entry per cycle at most; there is a single write port.

Reset
REQ-021 SHALL, when i_rstn=0, asynchronously clear all rf_arr entries to 0, independent of i_clk.
REQ-022 SHALL drive both read outputs to 0 during reset, as a consequence of REQ-015.
REQ-023 SHALL ignore i_rf_wr_en while i_rstn=0.
REQ-024 SHALL perform normal writes starting at the first i_clk rising edge after i_rstn is deasserted.
REQ-025 SHALL, if reset asserts mid-operation, cancel any pending write and clear the array immediately.

Structure
REQ-026 SHALL keep the default BW_DATA and BW_ADDR values as constants in the shared project package; the module parameters override them.
REQ-027 SHALL be a single flat module with no sub-modules; the write-enable decode and the two read multiplexers are inline logic.

Verification
REQ-028 SHALL check reset: assert i_rstn=0 and set rd_addr0=5, rd_addr1=15 -> o_rf_rd_data0 = o_rf_rd_data1 = 0.
REQ-029 SHALL check sequential fill and readback: write rf_arr[i]=i for i=0..15, then set rd_addr0=rd_addr1=i -> both outputs equal i for every i.
REQ-030 SHALL check random writes: write a random value (e.g. 0xBEEF) to address 7, then read address 7 one cycle later -> both outputs = 0xBEEF and all other entries are unchanged.
REQ-031 SHALL check write disable: hold wr_en=0 with wr_addr=3 and wr_data=0xFFFF for one edge -> rd of address 3 still returns its prior value (3).
REQ-032 SHALL check read during write: set rd_addr0=2 while writing 0x1234 to address 2 -> output shows the old value before the edge and 0x1234 after it.
REQ-033 SHALL check dual-port independence: set rd_addr0=0 and rd_addr1=15 after the fill in REQ-029 -> o_rf_rd_data0=0 and o_rf_rd_data1=15 in the same cycle.
